multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle MIPS core, replacing the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with a variable-latency memory through `mem_ready`. It drives the shared-ALU/shared-memory datapath and covers the full existing instruction set. It adds sub-word store/load sizing, an optional memory-timeout watchdog, and sticky error reporting.

## Interface
- `ALUOP_W`, 4: width of `aluop`. Codes are zero-extended when `ALUOP_W` > 4. Minimum value is 4.
- `MEM_TIMEOUT`, 15: maximum consecutive wait cycles without `mem_ready` before a memory error is flagged. Minimum value is 1.

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  6  opcode from the instruction register (stable from DECODE until the next FETCH)
- `funct`  in  6  function field from the instruction register
- `mem_ready`  in  1  memory access complete this cycle
- `memread`, `iord`, `irwrite`, `pcwrite`, `branch`, `regwrite`, `regdst`, `memtoreg`, `alusrca`  out  1  datapath strobes/selects
- `memwrite`  out  2  00 none, 01 word, 10 half, 11 byte
- `alusrcb`  out  2  00 reg, 01 const 4, 10 signext imm, 11 signext imm<<2
- `pcsrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr)
- `aluop`  out  `ALUOP_W`  codes: 0000 add, 0001 sub, 0011 or, 0111 and, 0101 xor, 0110 slt, 0100 lui, 1111 use funct
- `ne`, `lez`, `half`, `b`, `lbu`, `link`, `jr`  out  1  branch-sense and load/link qualifiers
- `mem_err`  out  1  sticky: memory timeout
- `ill_op`  out  1  sticky: illegal opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, IEXE, IWB, BRANCH, JUMP, JAL, JR, ERR.
- **FETCH:** `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=add.
  - While `mem_ready`=0, stay in FETCH.
  - When `mem_ready`=1, assert `irwrite`=`pcwrite`=1 and `pcsrc`=00 in the same cycle, then go to DECODE.
- **DECODE:** `alusrcb`=11, `aluop`=add (branch target into ALUOut). Next state by opcode:
  - op=0 with funct=001000 → JR.
  - op=0 otherwise → RTEXE.
  - lw/lh/lb/lbu/sw/sh/sb → MEMADR.
  - addi/ori/andi/xori/lui/slti → IEXE.
  - beq/bne/blez → BRANCH.
  - j → JUMP.
  - jal → JAL.
  - Any other opcode → ERR with `ill_op`=1.
- **MEMADR:** `alusrca`=1, `alusrcb`=10, `aluop`=add. Loads go to MEMRD; stores go to MEMWR.
- **MEMRD:** `memread`=1, `iord`=1. `half`/`b`/`lbu` are set per opcode (lh: `half`; lb: `half`,`b`; lbu: `lbu`). Wait for `mem_ready`, then go to MEMWB.
- **MEMWB:** `regwrite`=1, `memtoreg`=1, `regdst`=0. Qualifiers are held as in MEMRD. Go to FETCH.
- **MEMWR:** `iord`=1. `memwrite` is 01 for sw, 10 for sh, 11 for sb, held every cycle until `mem_ready`. Then go to FETCH.
- **RTEXE:** `alusrca`=1, `alusrcb`=00, `aluop`=1111. Go to RTWB.
- **RTWB:** `regwrite`=1, `regdst`=1. Go to FETCH.
- **IEXE:** `alusrca`=1, `alusrcb`=10. `aluop` is add, or, and, xor, lui or slt respectively. Go to IWB.
- **IWB:** `regwrite`=1, `regdst`=0. `aluop` is held. Go to FETCH.
- **BRANCH:** `alusrca`=1, `alusrcb`=00, `aluop`=sub, `branch`=1, `pcsrc`=01. `ne`=1 for bne; `lez`=1 for blez. Go to FETCH.
- **JUMP:** `pcwrite`=1, `pcsrc`=10. Go to FETCH.
- **JAL:** `pcwrite`=1, `pcsrc`=10, `regwrite`=1, `link`=1. Go to FETCH.
- **JR:** `pcwrite`=1, `pcsrc`=11, `jr`=1. Go to FETCH.
- **ERR:** all strobes are 0. The error flags stay set. ERR is left only by reset.
- Any output not listed for a state is 0.

## Timing
- Outputs decode combinationally from state and `op`/`funct`. `irwrite`/`pcwrite` in FETCH are additionally gated by `mem_ready`. The state register has no combinational path from `op` to `mem_ready`.
- Cycle counts with zero wait states (`mem_ready`=1 on first cycle):
  - R-type and I-type ALU: 4
  - lw/lh/lb/lbu: 5
  - stores: 4
  - branch, j, jal, jr: 3
- Each wait cycle adds 1 to the count.
- Reset (`reset_n`=0, asynchronous):
  - state goes to FETCH; wait counter and `mem_err`/`ill_op` clear.
  - All outputs are forced to 0 while reset is asserted.
  - FETCH outputs appear in the first cycle after release.
  - Reset in the middle of an access aborts it with no write strobe after assertion.
- Wait counter (width `$clog2(MEM_TIMEOUT+1)`):
  - Clears on entry to FETCH, MEMRD or MEMWR, and when `mem_ready`=1.
  - Increments for each wait cycle with `mem_ready`=0.
  - When it equals `MEM_TIMEOUT` with `mem_ready`=0, the next state is ERR and `mem_err`=1 from that edge.
  - If `mem_ready` and the timeout occur in the same cycle, `mem_ready` wins.

## Configuration
- `MULTICYCLE_CTRL_TIMEOUT_EN` defined: wait counter and timeout-to-ERR transition are present.
- Not defined: no counter; wait states last indefinitely; `mem_err` is tied to 0. ERR remains reachable via `ill_op`.

## Test plan
- Release reset, `mem_ready`=1, op=000000 funct=100000 → states FETCH, DECODE, RTEXE, RTWB. `regwrite`=`regdst`=1 in cycle 4; `irwrite`=1 only in cycle 1.
- lw with `mem_ready` low for 3 cycles in MEMRD → total 8 cycles; `iord`=1 throughout MEMRD; `regwrite`+`memtoreg` for exactly 1 cycle.
- sb, then sh, then sw → `memwrite` is 11, 10, 01 respectively, each for one MEMWR cycle.
- bne (op=000101) → BRANCH with `branch`=1, `ne`=1, `pcsrc`=01, `aluop`=0001; jr (op=0, funct=001000) → `pcwrite`=1, `pcsrc`=11 in cycle 3.
- op=111111 → ERR after DECODE, `ill_op`=1, all strobes 0 until `reset_n` low.
- With macro defined, hold `mem_ready`=0 in FETCH → `mem_err`=1 after exactly 16 cycles (`MEM_TIMEOUT`=15 plus 1); `mem_ready`=1 on the 16th cycle → normal DECODE instead.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM of the multicycle MIPS core. Sequences every
//   instruction through fetch / decode / execute / memory / writeback and
//   handshakes with a variable-latency memory through i_mem_ready.
//   Outputs are decoded combinationally from the state register and
//   i_op/i_funct and are forced to 0 while i_reset_n is low.
//
// Ports
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_op, i_funct          opcode / function field from the instruction register
//   i_mem_ready            memory access completes this cycle
//   o_memread ... o_alusrca  datapath strobes/selects
//   o_memwrite             00 none, 01 word, 10 half, 11 byte
//   o_alusrcb, o_pcsrc     ALU operand B / PC source selects
//   o_aluop                ALU code, zero-extended to ALUOP_W
//   o_ne ... o_jr          branch-sense and load/link qualifiers
//   o_mem_err, o_ill_op    sticky error flags (cleared only by reset)
//
// Build option
//   MULTICYCLE_CTRL_TIMEOUT_EN : adds the memory wait counter and the
//   timeout-to-ERR transition. Without it waits are unbounded and
//   o_mem_err is tied to 0.
//
// state  | meaning
// FETCH  | read instruction, PC+4; waits on memory
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | effective address for loads/stores
// MEMRD  | data read; waits on memory
// MEMWB  | load result into register file
// MEMWR  | data write (word/half/byte); waits on memory
// RTEXE  | R-type ALU operation
// RTWB   | R-type writeback (rd)
// IEXE   | immediate ALU operation
// IWB    | immediate writeback (rt)
// BRANCH | compare and conditional PC update
// JUMP   | j
// JAL    | jal (PC update + link)
// JR     | jr
// ERR    | dead state, left only by reset

module multicycle_ctrl #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [5:0]         i_op,
    input  logic [5:0]         i_funct,
    input  logic               i_mem_ready,
    output logic               o_memread,
    output logic               o_iord,
    output logic               o_irwrite,
    output logic               o_pcwrite,
    output logic               o_branch,
    output logic               o_regwrite,
    output logic               o_regdst,
    output logic               o_memtoreg,
    output logic               o_alusrca,
    output logic [1:0]         o_memwrite,
    output logic [1:0]         o_alusrcb,
    output logic [1:0]         o_pcsrc,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic               o_ne,
    output logic               o_lez,
    output logic               o_half,
    output logic               o_b,
    output logic               o_lbu,
    output logic               o_link,
    output logic               o_jr,
    output logic               o_mem_err,
    output logic               o_ill_op
);

    if (ALUOP_W < 4 || MEM_TIMEOUT < 1) begin : g_param_check
        $error("multicycle_ctrl: ALUOP_W must be >= 4 and MEM_TIMEOUT >= 1");
    end

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                           OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_BLEZ = 6'b000110,
                           OP_ADDI  = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100,
                           OP_ORI   = 6'b001101, OP_XORI = 6'b001110, OP_LUI  = 6'b001111,
                           OP_LB    = 6'b100000, OP_LH   = 6'b100001, OP_LW   = 6'b100011,
                           OP_LBU   = 6'b100100, OP_SB   = 6'b101000, OP_SH   = 6'b101001,
                           OP_SW    = 6'b101011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_OR  = 4'b0011,
                           ALU_AND = 4'b0111, ALU_XOR = 4'b0101, ALU_SLT = 4'b0110,
                           ALU_LUI = 4'b0100, ALU_FN  = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXE, S_RTWB,
        S_IEXE, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ERR
    } state_t;

    state_t     r_state;
    logic       r_ill_op;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_imm;
    logic       w_is_branch;
    logic [3:0] w_imm_aluop;
    logic [1:0] w_store_size;
    logic [3:0] w_aluop;
    logic       w_timeout;

    always_comb begin
        w_is_load   = (i_op == OP_LW) || (i_op == OP_LH) || (i_op == OP_LB) || (i_op == OP_LBU);
        w_is_store  = (i_op == OP_SW) || (i_op == OP_SH) || (i_op == OP_SB);
        w_is_branch = (i_op == OP_BEQ) || (i_op == OP_BNE) || (i_op == OP_BLEZ);
        w_is_imm    = 1'b1;
        w_imm_aluop = ALU_ADD;
        case (i_op)
            OP_ADDI: w_imm_aluop = ALU_ADD;
            OP_ORI:  w_imm_aluop = ALU_OR;
            OP_ANDI: w_imm_aluop = ALU_AND;
            OP_XORI: w_imm_aluop = ALU_XOR;
            OP_LUI:  w_imm_aluop = ALU_LUI;
            OP_SLTI: w_imm_aluop = ALU_SLT;
            default: w_is_imm    = 1'b0;
        endcase
        case (i_op)
            OP_SW:   w_store_size = 2'b01;
            OP_SH:   w_store_size = 2'b10;
            OP_SB:   w_store_size = 2'b11;
            default: w_store_size = 2'b00;
        endcase
    end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic              w_wait_state;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // A completing access in the timeout cycle still wins: timeout needs !ready.
    assign w_timeout    = w_wait_state && !i_mem_ready && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));

    // Counter is zero outside the wait states, so every entry into one starts at 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (w_wait_state && !i_mem_ready) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                              r_wait_cnt <= '0;
            if (w_timeout) r_mem_err <= 1'b1;
        end
    end

    assign o_mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign o_mem_err = 1'b0;
`endif

    assign o_ill_op = r_ill_op;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_FETCH;
            r_ill_op <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_mem_ready)    r_state <= S_DECODE;
                    else if (w_timeout) r_state <= S_ERR;
                end
                S_DECODE: begin
                    if (i_op == OP_RTYPE)             r_state <= (i_funct == FUNCT_JR) ? S_JR : S_RTEXE;
                    else if (w_is_load || w_is_store) r_state <= S_MEMADR;
                    else if (w_is_imm)                r_state <= S_IEXE;
                    else if (w_is_branch)             r_state <= S_BRANCH;
                    else if (i_op == OP_J)            r_state <= S_JUMP;
                    else if (i_op == OP_JAL)          r_state <= S_JAL;
                    else begin
                        r_state  <= S_ERR;
                        r_ill_op <= 1'b1;
                    end
                end
                S_MEMADR: r_state <= w_is_load ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (i_mem_ready)    r_state <= S_MEMWB;
                    else if (w_timeout) r_state <= S_ERR;
                end
                S_MEMWR: begin
                    if (i_mem_ready)    r_state <= S_FETCH;
                    else if (w_timeout) r_state <= S_ERR;
                end
                S_RTEXE: r_state <= S_RTWB;
                S_IEXE:  r_state <= S_IWB;
                S_MEMWB, S_RTWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR: r_state <= S_FETCH;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        o_memread  = 1'b0;  o_iord     = 1'b0;  o_irwrite = 1'b0;  o_pcwrite = 1'b0;
        o_branch   = 1'b0;  o_regwrite = 1'b0;  o_regdst  = 1'b0;  o_memtoreg = 1'b0;
        o_alusrca  = 1'b0;  o_memwrite = 2'b00; o_alusrcb = 2'b00; o_pcsrc   = 2'b00;
        o_ne       = 1'b0;  o_lez      = 1'b0;  o_half    = 1'b0;  o_b       = 1'b0;
        o_lbu      = 1'b0;  o_link     = 1'b0;  o_jr      = 1'b0;
        w_aluop    = ALU_ADD;
        if (i_reset_n) begin
            case (r_state)
                S_FETCH: begin
                    o_memread = 1'b1;
                    o_alusrcb = 2'b01;
                    o_irwrite = i_mem_ready;
                    o_pcwrite = i_mem_ready;
                end
                S_DECODE: o_alusrcb = 2'b11;
                S_MEMADR: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = 2'b10;
                end
                S_MEMRD, S_MEMWB: begin
                    o_memread  = (r_state == S_MEMRD);
                    o_iord     = (r_state == S_MEMRD);
                    o_regwrite = (r_state == S_MEMWB);
                    o_memtoreg = (r_state == S_MEMWB);
                    o_half     = (i_op == OP_LH) || (i_op == OP_LB);
                    o_b        = (i_op == OP_LB);
                    o_lbu      = (i_op == OP_LBU);
                end
                S_MEMWR: begin
                    o_iord     = 1'b1;
                    o_memwrite = w_store_size;
                end
                S_RTEXE: begin
                    o_alusrca = 1'b1;
                    w_aluop   = ALU_FN;
                end
                S_RTWB: begin
                    o_regwrite = 1'b1;
                    o_regdst   = 1'b1;
                end
                S_IEXE: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = 2'b10;
                    w_aluop   = w_imm_aluop;
                end
                S_IWB: begin
                    o_regwrite = 1'b1;
                    w_aluop    = w_imm_aluop;
                end
                S_BRANCH: begin
                    o_alusrca = 1'b1;
                    o_branch  = 1'b1;
                    o_pcsrc   = 2'b01;
                    w_aluop   = ALU_SUB;
                    o_ne      = (i_op == OP_BNE);
                    o_lez     = (i_op == OP_BLEZ);
                end
                S_JUMP, S_JAL: begin
                    o_pcwrite  = 1'b1;
                    o_pcsrc    = 2'b10;
                    o_regwrite = (r_state == S_JAL);
                    o_link     = (r_state == S_JAL);
                end
                S_JR: begin
                    o_pcwrite = 1'b1;
                    o_pcsrc   = 2'b11;
                    o_jr      = 1'b1;
                end
                default: ;
            endcase
        end
        o_aluop      = '0;
        o_aluop[3:0] = w_aluop;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       memread, iord, irwrite, pcwrite, branch, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] memwrite, alusrcb, pcsrc;
    logic [3:0] aluop;
    logic       ne, lez, half, b, lbu, link, jr, mem_err, ill_op;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_op(op), .i_funct(funct), .i_mem_ready(mem_ready),
        .o_memread(memread), .o_iord(iord), .o_irwrite(irwrite), .o_pcwrite(pcwrite),
        .o_branch(branch), .o_regwrite(regwrite), .o_regdst(regdst), .o_memtoreg(memtoreg),
        .o_alusrca(alusrca), .o_memwrite(memwrite), .o_alusrcb(alusrcb), .o_pcsrc(pcsrc),
        .o_aluop(aluop), .o_ne(ne), .o_lez(lez), .o_half(half), .o_b(b), .o_lbu(lbu),
        .o_link(link), .o_jr(jr), .o_mem_err(mem_err), .o_ill_op(ill_op)
    );

    typedef struct packed {
        logic       memread, iord, irwrite, pcwrite, branch, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] memwrite, alusrcb, pcsrc;
        logic [3:0] aluop;
        logic       ne, lez, half, b, lbu, link, jr, mem_err, ill_op;
    } ov_t;

    typedef struct packed {
        ov_t        exp;
        logic       rdy;
        logic [5:0] op;
        logic [5:0] funct;
    } cyc_t;

    typedef enum int {K_R, K_JR, K_LOAD, K_STORE, K_IMM, K_BR, K_J, K_JAL, K_ILL} kind_t;

    cyc_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   cnt_irwrite, cnt_memtoreg, cnt_iord, cnt_memwrite;

    logic [5:0] legal_ops [19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h08, 6'h0A,
                                   6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24,
                                   6'h28, 6'h29, 6'h2B};

    function automatic ov_t dut_out();
        ov_t o;
        o.memread = memread;   o.iord = iord;         o.irwrite = irwrite;   o.pcwrite = pcwrite;
        o.branch = branch;     o.regwrite = regwrite; o.regdst = regdst;     o.memtoreg = memtoreg;
        o.alusrca = alusrca;   o.memwrite = memwrite; o.alusrcb = alusrcb;   o.pcsrc = pcsrc;
        o.aluop = aluop;       o.ne = ne;             o.lez = lez;           o.half = half;
        o.b = b;               o.lbu = lbu;           o.link = link;         o.jr = jr;
        o.mem_err = mem_err;   o.ill_op = ill_op;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction classes straight from the opcode table.
    function automatic kind_t kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:                      return (f == 6'h08) ? K_JR : K_R;
            6'h20, 6'h21, 6'h23, 6'h24: return K_LOAD;
            6'h28, 6'h29, 6'h2B:        return K_STORE;
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_IMM;
            6'h04, 6'h05, 6'h06:        return K_BR;
            6'h02:                      return K_J;
            6'h03:                      return K_JAL;
            default:                    return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] imm_code(input logic [5:0] o);
        case (o)
            6'h0D:   return 4'b0011;
            6'h0C:   return 4'b0111;
            6'h0E:   return 4'b0101;
            6'h0F:   return 4'b0100;
            6'h0A:   return 4'b0110;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input ov_t e, input logic rdy, input logic [5:0] o, input logic [5:0] f);
        cyc_t c;
        c.exp = e; c.rdy = rdy; c.op = o; c.funct = f;
        q.push_back(c);
    endtask

    // Expands one instruction into its expected per-cycle output pattern.
    task automatic add_instr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
        ov_t   e;
        kind_t k;
        k = kind_of(o, f);
        for (int i = 0; i <= wf; i++) begin
            e = '0; e.memread = 1'b1; e.alusrcb = 2'b01;
            if (i == wf) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
            push(e, (i == wf), 6'($urandom), 6'($urandom));
        end
        e = '0; e.alusrcb = 2'b11;
        push(e, rbit(), o, f);
        case (k)
            K_R: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 4'b1111; push(e, rbit(), o, f);
                e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;  push(e, rbit(), o, f);
            end
            K_JR: begin
                e = '0; e.pcwrite = 1'b1; e.pcsrc = 2'b11; e.jr = 1'b1; push(e, rbit(), o, f);
            end
            K_LOAD, K_STORE: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; push(e, rbit(), o, f);
                for (int i = 0; i <= wm; i++) begin
                    e = '0; e.iord = 1'b1;
                    if (k == K_LOAD) begin
                        e.memread = 1'b1;
                        e.half = (o == 6'h21) || (o == 6'h20);
                        e.b    = (o == 6'h20);
                        e.lbu  = (o == 6'h24);
                    end else begin
                        e.memwrite = (o == 6'h2B) ? 2'b01 : (o == 6'h29) ? 2'b10 : 2'b11;
                    end
                    push(e, (i == wm), o, f);
                end
                if (k == K_LOAD) begin
                    e.memread = 1'b0; e.iord = 1'b0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
                    push(e, rbit(), o, f);
                end
            end
            K_IMM: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = imm_code(o); push(e, rbit(), o, f);
                e = '0; e.regwrite = 1'b1; e.aluop = imm_code(o);                   push(e, rbit(), o, f);
            end
            K_BR: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 4'b0001; e.branch = 1'b1; e.pcsrc = 2'b01;
                e.ne = (o == 6'h05); e.lez = (o == 6'h06);
                push(e, rbit(), o, f);
            end
            K_J, K_JAL: begin
                e = '0; e.pcwrite = 1'b1; e.pcsrc = 2'b10;
                e.regwrite = (k == K_JAL); e.link = (k == K_JAL);
                push(e, rbit(), o, f);
            end
            default: begin
                for (int i = 0; i < 6; i++) begin
                    e = '0; e.ill_op = 1'b1; push(e, rbit(), o, f);
                end
            end
        endcase
    endtask

    // Drive each planned cycle just after the rising edge, compare before the next one.
    task automatic run_queue(input int lim);
        cyc_t c;
        int   n;
        ov_t  a;
        n = 0;
        while (q.size() > 0 && n < lim) begin
            c = q.pop_front();
            mem_ready = c.rdy; op = c.op; funct = c.funct;
            #3;
            a = dut_out();
            check($sformatf("outputs@cyc%0d", cyc), a, c.exp);
            cnt_irwrite  += int'(a.irwrite);
            cnt_memtoreg += int'(a.regwrite & a.memtoreg);
            cnt_iord     += int'(a.iord);
            cnt_memwrite += int'(a.memwrite != 2'b00);
            @(posedge clk); #1;
            cyc++; n++;
        end
    endtask

    task automatic clr_cnt();
        cnt_irwrite = 0; cnt_memtoreg = 0; cnt_iord = 0; cnt_memwrite = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check("reset_outputs_zero", dut_out(), '0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [5:0] o, f;
        ov_t        e;
        @(posedge clk); #1;
        do_reset();

        // R-type add, zero waits.
        clr_cnt();
        add_instr(6'h00, 6'h20, 0, 0);
        check("len_rtype", q.size(), 4);
        run_queue(1000);
        check("rtype_irwrite_cycles", cnt_irwrite, 1);

        // lw with three wait cycles in MEMRD.
        clr_cnt();
        add_instr(6'h23, 6'h00, 0, 3);
        check("len_lw_3wait", q.size(), 8);
        run_queue(1000);
        check("lw_memtoreg_cycles", cnt_memtoreg, 1);
        check("lw_iord_cycles", cnt_iord, 4);

        // sb, sh, sw.
        clr_cnt();
        add_instr(6'h28, 6'h00, 0, 0);
        check("len_store", q.size(), 4);
        add_instr(6'h29, 6'h00, 0, 0);
        add_instr(6'h2B, 6'h00, 0, 0);
        run_queue(1000);
        check("store_memwrite_cycles", cnt_memwrite, 3);

        // bne, jr, j, jal, addi.
        add_instr(6'h05, 6'h00, 0, 0);
        check("len_branch", q.size(), 3);
        run_queue(1000);
        add_instr(6'h00, 6'h08, 0, 0);
        check("len_jr", q.size(), 3);
        add_instr(6'h02, 6'h00, 0, 0);
        add_instr(6'h03, 6'h00, 1, 0);
        add_instr(6'h0E, 6'h00, 0, 0);
        run_queue(1000);

        // Waits right at the timeout boundary complete normally.
        add_instr(6'h00, 6'h22, 15, 0);
        add_instr(6'h21, 6'h00, 0, 15);
        add_instr(6'h29, 6'h00, 15, 15);
        run_queue(1000);

        // Illegal opcode, then reset clears the sticky flag.
        add_instr(6'h3F, 6'h00, 0, 0);
        run_queue(1000);
        do_reset();

        // Reset in the middle of a store wait aborts the write.
        add_instr(6'h2B, 6'h00, 0, 6);
        run_queue(5);
        q.delete();
        do_reset();

        // Memory never responds during fetch.
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            e = '0; e.memread = 1'b1; e.alusrcb = 2'b01; push(e, 1'b0, 6'h00, 6'h20);
        end
        for (int i = 0; i < 4; i++) begin
            e = '0; e.mem_err = 1'b1; push(e, rbit(), 6'h00, 6'h20);
        end
        run_queue(1000);
        do_reset();
`else
        add_instr(6'h00, 6'h24, 40, 0);
        run_queue(1000);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            o = legal_ops[$urandom_range(0, 18)];
            f = ($urandom_range(0, 7) == 0) ? 6'h08 : 6'($urandom);
            add_instr(o, f, $urandom_range(0, 3), $urandom_range(0, 4));
            run_queue(1000);
        end

        // Random illegal opcodes.
        for (int n = 0; n < 4; n++) begin
            do begin
                o = 6'($urandom);
            end while (kind_of(o, 6'h00) != K_ILL);
            add_instr(6'h0D, 6'h00, $urandom_range(0, 2), 0);
            add_instr(o, 6'($urandom), $urandom_range(0, 2), 0);
            run_queue(1000);
            do_reset();
        end

        add_instr(6'h06, 6'h00, 0, 0);
        run_queue(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
